// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for the register file.
// Round-robin between A and B, one registered write per cycle, plus a saturating conflict counter.
module regfile_write_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 ReqA_valid,
  input  logic [4:0]           ReqA_addr,
  input  logic [31:0]          ReqA_data,
  output logic                 ReqA_ready,
  input  logic                 ReqB_valid,
  input  logic [4:0]           ReqB_addr,
  input  logic [31:0]          ReqB_data,
  output logic                 ReqB_ready,
  output logic [31:0]          WriteData,
  output logic [4:0]           WriteRegister,
  output logic                 RegWrite,
  output logic [CNT_WIDTH-1:0] ConflictCount
);

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic        prio;
  logic        xfer_a;
  logic        xfer_b;
  logic        conflict;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // Readies depend only on the valids and the pointer; reset gates them so nothing transfers.
  always_comb begin
    ReqA_ready = Reset_n && ReqA_valid && (!ReqB_valid || (prio == PRIO_A));
    ReqB_ready = Reset_n && ReqB_valid && (!ReqA_valid || (prio == PRIO_B));
    xfer_a     = ReqA_valid && ReqA_ready;
    xfer_b     = ReqB_valid && ReqB_ready;
    conflict   = ReqA_valid && ReqB_valid;
    sel_addr   = xfer_b ? ReqB_addr : ReqA_addr;
    sel_data   = xfer_b ? ReqB_data : ReqA_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prio <= PRIO_A;
    end else if (xfer_a) begin
      prio <= PRIO_B;
    end else if (xfer_b) begin
      prio <= PRIO_A;
    end
  end

  // Register 0 is hardwired, so its writes are accepted but never enabled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite      <= 1'b0;
      WriteData     <= 32'h0;
      WriteRegister <= 5'h0;
    end else begin
      RegWrite <= (xfer_a || xfer_b) && (sel_addr != 5'h0);
      if (xfer_a || xfer_b) begin
        WriteData     <= sel_data;
        WriteRegister <= sel_addr;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ConflictCount <= '0;
    end else if (conflict && (ConflictCount != CNT_MAX)) begin
      ConflictCount <= ConflictCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a reference grant model pushes expected writes
// into a queue that is popped one cycle later when the write stage presents them.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        Clk;
  logic        Reset_n;
  logic        ReqA_valid, ReqB_valid;
  logic [4:0]  ReqA_addr, ReqB_addr;
  logic [31:0] ReqA_data, ReqB_data;
  logic        ReqA_ready, ReqB_ready;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite;
  logic [15:0] ConflictCount;

  logic        ReqA_ready4, ReqB_ready4;
  logic [31:0] WriteData4;
  logic [4:0]  WriteRegister4;
  logic        RegWrite4;
  logic [3:0]  ConflictCount4;

  wr_t         exp_q[$];
  logic        m_prio_b;
  logic [15:0] m_cnt16;
  logic [3:0]  m_cnt4;
  logic [4:0]  m_last_addr;
  logic [31:0] m_last_data;
  int          check_count = 0;
  int          pass_count  = 0;

  regfile_write_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqA_valid(ReqA_valid), .ReqA_addr(ReqA_addr), .ReqA_data(ReqA_data), .ReqA_ready(ReqA_ready),
    .ReqB_valid(ReqB_valid), .ReqB_addr(ReqB_addr), .ReqB_data(ReqB_data), .ReqB_ready(ReqB_ready),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
    .ConflictCount(ConflictCount)
  );

  regfile_write_arbiter #(.CNT_WIDTH(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqA_valid(ReqA_valid), .ReqA_addr(ReqA_addr), .ReqA_data(ReqA_data), .ReqA_ready(ReqA_ready4),
    .ReqB_valid(ReqB_valid), .ReqB_addr(ReqB_addr), .ReqB_data(ReqB_data), .ReqB_ready(ReqB_ready4),
    .WriteData(WriteData4), .WriteRegister(WriteRegister4), .RegWrite(RegWrite4),
    .ConflictCount(ConflictCount4)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_regwrite"}, {31'h0, RegWrite}, 32'h0);
    check({tag, "_wdata"}, WriteData, 32'h0);
    check({tag, "_wreg"}, {27'h0, WriteRegister}, 32'h0);
    check({tag, "_cnt16"}, {16'h0, ConflictCount}, 32'h0);
    check({tag, "_cnt4"}, {28'h0, ConflictCount4}, 32'h0);
    check({tag, "_ready_a"}, {31'h0, ReqA_ready}, 32'h0);
    check({tag, "_ready_b"}, {31'h0, ReqB_ready}, 32'h0);
  endtask

  task automatic model_reset();
    m_prio_b    = 1'b0;
    m_cnt16     = '0;
    m_cnt4      = '0;
    m_last_addr = '0;
    m_last_data = '0;
    exp_q.delete();
  endtask

  // Pops the write the model predicted for this cycle and compares both instances.
  task automatic check_output(input string tag);
    wr_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'h1, 32'h0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_regwrite"}, {31'h0, RegWrite}, {31'h0, e.we});
    check({tag, "_wreg"}, {27'h0, WriteRegister}, {27'h0, e.addr});
    check({tag, "_wdata"}, WriteData, e.data);
    check({tag, "_regwrite4"}, {31'h0, RegWrite4}, {31'h0, e.we});
    check({tag, "_wdata4"}, WriteData4, e.data);
    check({tag, "_cnt16"}, {16'h0, ConflictCount}, {16'h0, m_cnt16});
    check({tag, "_cnt4"}, {28'h0, ConflictCount4}, {28'h0, m_cnt4});
  endtask

  // Drives one cycle just after a rising edge, checks the readies, then the registered result.
  task automatic apply_stimulus(input string tag,
                                input logic va, input logic [4:0] aa, input logic [31:0] da,
                                input logic vb, input logic [4:0] ab, input logic [31:0] db,
                                output logic ga, output logic gb);
    wr_t e;
    ReqA_valid = va; ReqA_addr = aa; ReqA_data = da;
    ReqB_valid = vb; ReqB_addr = ab; ReqB_data = db;
    ga = va && (!vb || !m_prio_b);
    gb = vb && (!va || m_prio_b);
    #2;
    check({tag, "_ready_a"}, {31'h0, ReqA_ready}, {31'h0, ga});
    check({tag, "_ready_b"}, {31'h0, ReqB_ready}, {31'h0, gb});
    check({tag, "_ready_a4"}, {31'h0, ReqA_ready4}, {31'h0, ga});
    if (ga || gb) begin
      m_last_addr = ga ? aa : ab;
      m_last_data = ga ? da : db;
      m_prio_b    = ga;
    end
    e.we   = (ga || gb) && (m_last_addr != 5'h0);
    e.addr = m_last_addr;
    e.data = m_last_data;
    exp_q.push_back(e);
    if (va && vb) begin
      if (m_cnt16 != 16'hFFFF) m_cnt16 = m_cnt16 + 16'h1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'h1;
    end
    @(posedge Clk);
    #1;
    check_output(tag);
  endtask

  initial begin
    logic        ga, gb;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;

    $display("[TB] start");
    model_reset();
    Reset_n = 1'b0;
    ReqA_valid = 1'b1; ReqA_addr = 5'd3; ReqA_data = 32'h1;
    ReqB_valid = 1'b1; ReqB_addr = 5'd4; ReqB_data = 32'h2;
    #3;
    check_reset_state("reset_init");
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check_reset_state("reset_held");
    Reset_n = 1'b1;

    apply_stimulus("a_only", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, ga, gb);
    apply_stimulus("idle_hold", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ga, gb);
    apply_stimulus("b_addr0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678, ga, gb);
    apply_stimulus("idle_after0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ga, gb);

    a_addr = 5'd3; a_data = 32'h1111_0001;
    b_addr = 5'd4; b_data = 32'h2222_0001;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus("both4", 1'b1, a_addr, a_data, 1'b1, b_addr, b_data, ga, gb);
      check("both4_grant_order", {31'h0, ga}, (i % 2 == 0) ? 32'h1 : 32'h0);
      if (ga) begin a_data = a_data + 32'h1; a_addr = a_addr + 5'd2; end
      if (gb) begin b_data = b_data + 32'h1; b_addr = b_addr + 5'd2; end
    end
    check("both4_conflicts", {16'h0, ConflictCount}, 32'd4);

    apply_stimulus("same_addr_1", 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, ga, gb);
    check("same_addr_first_data", WriteData, 32'h1);
    apply_stimulus("same_addr_2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h2, ga, gb);
    check("same_addr_final_data", WriteData, 32'h2);

    a_addr = 5'd1; a_data = $urandom;
    b_addr = 5'd2; b_data = $urandom;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus("sat20", 1'b1, a_addr, a_data, 1'b1, b_addr, b_data, ga, gb);
      if (ga) begin a_data = $urandom; a_addr = 5'($urandom_range(31, 1)); end
      if (gb) begin b_data = $urandom; b_addr = 5'($urandom_range(31, 1)); end
    end
    check("sat_cnt4_max", {28'h0, ConflictCount4}, 32'hF);
    check("sat_cnt16_value", {16'h0, ConflictCount}, 32'd25);

    apply_stimulus("pre_reset_write", 1'b1, 5'd9, 32'hA5A5_0009, 1'b0, 5'd0, 32'h0, ga, gb);
    check("pre_reset_regwrite", {31'h0, RegWrite}, 32'h1);
    ReqA_valid = 1'b1; ReqA_addr = 5'd10; ReqA_data = 32'hBBBB_000A;
    ReqB_valid = 1'b1; ReqB_addr = 5'd11; ReqB_data = 32'hCCCC_000B;
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_state("reset_mid");
    @(posedge Clk);
    #1;
    check_reset_state("reset_mid_edge");
    Reset_n = 1'b1;
    model_reset();

    apply_stimulus("post_reset_both", 1'b1, 5'd10, 32'hBBBB_000A, 1'b1, 5'd11, 32'hCCCC_000B, ga, gb);
    check("post_reset_a_first", {31'h0, ga}, 32'h1);
    apply_stimulus("post_reset_b", 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hCCCC_000B, ga, gb);
    apply_stimulus("post_reset_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ga, gb);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter CNT_WIDTH, default 16, SHALL set the width of ConflictCount.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 ReqA_valid  input  1  SHALL indicate requester A holds a pending write.
REQ-005 ReqA_addr  input  5  SHALL be requester A's destination register address.
REQ-006 ReqA_data  input  32  SHALL be requester A's write data.
REQ-007 ReqA_ready  output  1  SHALL indicate the arbiter accepts A's write this cycle.
REQ-008 ReqB_valid, ReqB_addr, ReqB_data, ReqB_ready SHALL mirror the A ports, same directions and widths, for requester B.
REQ-009 WriteData  output  32  SHALL drive the register file write-data input.
REQ-010 WriteRegister  output  5  SHALL drive the register file write address.
REQ-011 RegWrite  output  1  SHALL drive the register file write enable.
REQ-012 ConflictCount  output  CNT_WIDTH  SHALL count cycles in which both requesters were valid.

Function
REQ-013 A transfer on port X SHALL occur at a rising Clk edge where ReqX_valid and ReqX_ready are both 1.
REQ-014 ReqX_ready SHALL be combinational from the valids and the priority pointer, with no combinational dependence on addr or data.
REQ-015 Grant rule: only one valid -> that port ready; both valid -> the port named by the priority pointer ready and the other 0; neither valid -> both ready 0.
REQ-016 At most one ReqX_ready SHALL be 1 in any cycle.
REQ-017 Priority pointer: 1 bit, SHALL move to the non-granted port after every transfer and hold when no transfer occurs.
REQ-018 A requester SHALL hold valid, addr and data stable until its transfer; the arbiter need not tolerate withdrawal.
REQ-019 Output stage, on transfer: the next cycle SHALL present WriteData = accepted data, WriteRegister = accepted addr, and RegWrite = 1 (fixed 1-cycle latency).
REQ-020 Transfer with addr = 0: the transfer SHALL complete (ready high), WriteData/WriteRegister SHALL update, and RegWrite SHALL stay 0 (register 0 never written).
REQ-021 Cycle without transfer: RegWrite SHALL be 0 next cycle, and WriteData/WriteRegister SHALL hold their last values.
REQ-022 Back-to-back transfers SHALL sustain one write per cycle; throughput SHALL be 1 write/cycle total.
REQ-023 Both valid to the same address: writes SHALL NOT merge; they SHALL issue on consecutive cycles in pointer order, so the later-granted data is the final register value.
REQ-024 ConflictCount SHALL increment by 1 on each edge where ReqA_valid and ReqB_valid are both 1, and SHALL saturate at all-ones (no wrap).
REQ-025 Fairness: a continuously valid requester SHALL be granted within 2 cycles.

Reset
REQ-026 While Reset_n = 0: RegWrite = 0, WriteData = 0, WriteRegister = 0, ConflictCount = 0, and pointer = A, all asserted asynchronously.
REQ-027 While Reset_n = 0, ReqA_ready and ReqB_ready SHALL be 0, and no transfer SHALL occur.
REQ-028 On reset mid-operation, a write registered but not yet presented SHALL be discarded, and RegWrite SHALL drop immediately without waiting for Clk.
REQ-029 The first edge after Reset_n rises SHALL apply the normal grant rule with A priority.

Verification
REQ-030 After reset, A only valid: addr=5, data=0xDEADBEEF -> ReqA_ready=1 same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF.
REQ-031 A and B both valid for 4 cycles with fresh writes each accept: grants A,B,A,B; RegWrite=1 on 4 consecutive cycles; ConflictCount=4.
REQ-032 B only valid: addr=0, data=0x12345678 -> ReqB_ready=1; next cycle RegWrite=0, WriteRegister=0.
REQ-033 A and B both valid to addr 7: A data=0x1, B data=0x2 -> writes 0x1 then 0x2 on consecutive cycles.
REQ-034 Run with CNT_WIDTH=4 and both valid for 20 cycles -> ConflictCount stops at 0xF.
REQ-035 Assert Reset_n=0 mid-cycle with RegWrite=1 -> RegWrite, WriteData and ConflictCount are 0 before the next Clk edge, and both readies are 0.
